mem_access_unit: RTL and testbench

- Parametrised successor to the combinational load formatter: a sequential MEM-stage load/store unit.
- Accepts one load or store per transaction from EX/MEM and checks alignment.
- Drives a req/ack data-memory handshake with timeout, builds byte strobes for stores, and lane-selects plus sign/zero-extends load data into a registered result.
- Holds the pipeline stall while a transaction is outstanding.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/load_formatter.sv | 42 ++++
 rtl/mem_access_unit.sv | 212 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - ls size encodings (i_ls_type[1:0]) and the position of the unsigned bit
//   - FSM state encoding
//   - strb_width(): number of bytes touched by an access of a given size
package mem_pkg;

    localparam logic [1:0] LS_BYTE   = 2'b00;
    localparam logic [1:0] LS_HALF   = 2'b01;
    localparam logic [1:0] LS_WORD   = 2'b11;
    localparam logic [1:0] LS_DOUBLE = 2'b10;

    localparam int LS_UNSIGNED = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic int unsigned strb_width(input logic [1:0] size);
        case (size)
            LS_BYTE: return 1;
            LS_HALF: return 2;
            LS_WORD: return 4;
            default: return 8;
        endcase
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load formatter: selects the addressed lane of a memory word
// and sign- or zero-extends it to the full data width.
// Ports:
//   rdata   in  DATA_W     raw memory read data
//   offset  in  log2(B)    byte offset of the access inside the word
//   ls_type in  3          [1:0] size, [2] unsigned
//   data    out DATA_W     formatted, right-justified result
module load_formatter
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]            rdata,
    input  logic [$clog2(DATA_W/8)-1:0]  offset,
    input  logic [2:0]                   ls_type,
    output logic [DATA_W-1:0]            data
);

    localparam int          IDX_W = $clog2(DATA_W);
    localparam int unsigned DW_U  = DATA_W;

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic [IDX_W-1:0]  msb_idx;
    logic              sign;
    int unsigned       bits;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        bits    = strb_width(ls_type[1:0]) * 8;
        // A full-width lane needs no extension; the clamp also keeps the
        // MSB index in range for sizes wider than the bus.
        if (bits > DW_U) begin
            bits = DW_U;
        end
        mask    = ~({DATA_W{1'b1}} << bits);
        msb_idx = IDX_W'(bits - 1);
        sign    = !ls_type[LS_UNSIGNED] && shifted[msb_idx];
        data    = (shifted & mask) | (sign ? ~mask : '0);
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit. Accepts one load or store in IDLE, checks
// alignment, runs a req/ack data-memory handshake with a timeout, builds
// store strobes/lane-shifted data and registers the formatted load result.
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_valid, i_is_store, i_ls_type transaction request (sampled in IDLE)
//   i_addr, i_store_data           byte address, right-justified store data
//   o_stall                        pipeline hold while a transaction is live
//   o_mem_req/we/addr/wstrb/wdata  data-memory request side
//   i_mem_ack, i_mem_rdata         data-memory response side
//   o_done                         one-cycle completion pulse
//   o_load_data                    last formatted load result
//   o_misaligned, o_bus_error      one-cycle exception pulses
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic                  i_is_store,
    input  logic [2:0]            i_ls_type,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W-1:0]     i_store_data,
    output logic                  o_stall,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W/8-1:0]   o_mem_wstrb,
    output logic [DATA_W-1:0]     o_mem_wdata,
    input  logic                  i_mem_ack,
    input  logic [DATA_W-1:0]     i_mem_rdata,
    output logic                  o_done,
    output logic [DATA_W-1:0]     o_load_data,
    output logic                  o_misaligned,
    output logic                  o_bus_error
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned DW_U  = DATA_W;
    localparam int          OFF_W = $clog2(DATA_W / 8);
    localparam int          CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t state, state_next;

    logic [CNT_W-1:0]  cnt;
    logic              timeout_hit;

    logic [OFF_W-1:0]  in_off;
    logic [1:0]        in_size;
    int unsigned       in_bytes;
    logic              in_mis;
    logic [BYTES-1:0]  in_wstrb;
    logic [DATA_W-1:0] in_wdata;
    logic              accept;
    logic              accept_ok;
    logic              req_end;

    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [BYTES-1:0]  wstrb_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        type_q;
    logic [OFF_W-1:0]  off_q;
    logic [DATA_W-1:0] load_data_q;
    logic [DATA_W-1:0] fmt_data;
    logic              mis_q;
    logic              bus_err_q;

    function automatic logic [DATA_W-1:0] lane_mask(input int unsigned nbytes);
        int unsigned bits;
        bits = nbytes * 8;
        if (bits > DW_U) begin
            bits = DW_U;
        end
        return ~({DATA_W{1'b1}} << bits);
    endfunction

    // ---- accept decode (IDLE, cycle N) ----
    assign in_off  = i_addr[OFF_W-1:0];
    assign in_size = i_ls_type[1:0];

    always_comb begin
        in_bytes = strb_width(in_size);
        // Offset must be a multiple of the size; a size wider than the bus
        // (double on a 32-bit unit) can never be aligned.
        in_mis   = ((in_off & OFF_W'(in_bytes - 1)) != '0) || (in_bytes > BYTES);
    end

    assign in_wstrb  = BYTES'((64'd1 << in_bytes) - 64'd1) << in_off;
    assign in_wdata  = (i_store_data & lane_mask(in_bytes)) << {in_off, 3'b000};

    assign accept    = (state == ST_IDLE) && i_valid;
    assign accept_ok = accept && !in_mis;

    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
    assign req_end     = (state == ST_REQ) && (i_mem_ack || timeout_hit);

    // ---- FSM: state register ----
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---- FSM: next state ----
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept_ok) state_next = ST_REQ;
            ST_REQ: begin
                // Ack wins over an expiring counter.
                if (i_mem_ack)        state_next = ST_RESP;
                else if (timeout_hit) state_next = ST_IDLE;
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        o_mem_req = 1'b0;
        o_done    = 1'b0;
        o_stall   = 1'b0;
        case (state)
            ST_IDLE: o_stall = i_valid && !in_mis && !i_reset;
            ST_REQ: begin
                o_mem_req = 1'b1;
                o_stall   = 1'b1;
            end
            ST_RESP: o_done = 1'b1;
            default: ;
        endcase
    end

    // ---- control: timeout counter and exception pulses ----
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt       <= '0;
            mis_q     <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            if (state == ST_REQ && !i_mem_ack && !timeout_hit) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            mis_q     <= accept && in_mis;
            bus_err_q <= (state == ST_REQ) && !i_mem_ack && timeout_hit;
        end
    end

    // ---- request registers (valid from N+1, held through REQ) ----
    // These drive outputs directly, so they are cleared on reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            addr_q      <= '0;
            we_q        <= 1'b0;
            wstrb_q     <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
        end else begin
            if (accept_ok) begin
                addr_q  <= {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                we_q    <= i_is_store;
                wstrb_q <= i_is_store ? in_wstrb : '0;
                wdata_q <= i_is_store ? in_wdata : '0;
            end else if (req_end) begin
                addr_q  <= '0;
                we_q    <= 1'b0;
                wstrb_q <= '0;
                wdata_q <= '0;
            end
            // ---- response: load result captured on the ack cycle ----
            if (state == ST_REQ && i_mem_ack && !we_q) begin
                load_data_q <= fmt_data;
            end
        end
    end

    // Access descriptor kept for the formatter; not visible at the ports.
    always_ff @(posedge i_clk) begin
        if (accept_ok) begin
            type_q <= i_ls_type;
            off_q  <= in_off;
        end
    end

    load_formatter #(
        .DATA_W (DATA_W)
    ) u_load_formatter (
        .rdata   (i_mem_rdata),
        .offset  (off_q),
        .ls_type (type_q),
        .data    (fmt_data)
    );

    assign o_mem_we     = we_q;
    assign o_mem_addr   = addr_q;
    assign o_mem_wstrb  = wstrb_q;
    assign o_mem_wdata  = wdata_q;
    assign o_load_data  = load_data_q;
    assign o_misaligned = mis_q;
    assign o_bus_error  = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (DATA_W=32, TIMEOUT=16).
// A byte-lane reference model predicts alignment, strobes, store data and
// load results; a bench-side memory acks after a chosen number of cycles.
module tb_mem_access_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic        i_is_store;
    logic [2:0]  i_ls_type;
    logic [31:0] i_addr;
    logic [31:0] i_store_data;
    logic        o_stall;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_wstrb;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_done;
    logic [31:0] o_load_data;
    logic        o_misaligned;
    logic        o_bus_error;

    int errors = 0;
    int checks = 0;

    logic [31:0] last_load;

    // observations of one transaction
    int          obs_req_cycles, obs_stall_after, obs_done_cyc, obs_mis_cyc, obs_err_cyc;
    int          obs_done_cnt, obs_pulse_cnt;
    logic        obs_stall_at_accept, obs_unstable, obs_timeout, obs_we;
    logic [31:0] obs_addr, obs_wdata, obs_load;
    logic [3:0]  obs_wstrb;

    mem_access_unit #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .i_is_store   (i_is_store),
        .i_ls_type    (i_ls_type),
        .i_addr       (i_addr),
        .i_store_data (i_store_data),
        .o_stall      (o_stall),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wstrb  (o_mem_wstrb),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_ack    (i_mem_ack),
        .i_mem_rdata  (i_mem_rdata),
        .o_done       (o_done),
        .o_load_data  (o_load_data),
        .o_misaligned (o_misaligned),
        .o_bus_error  (o_bus_error)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int m_bytes(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b11:   return 4;
            default: return 8;
        endcase
    endfunction

    function automatic bit m_mis(input logic [2:0] ty, input logic [31:0] a);
        int n;
        n = m_bytes(ty[1:0]);
        if (n > 4) return 1'b1;
        return ((a % 4) % n) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [2:0] ty);
        int n, off;
        logic [63:0] v;
        n = m_bytes(ty[1:0]);
        off = int'(a % 4);
        v = '0;
        for (int i = 0; i < n; i++) v[i*8 +: 8] = rd[(off+i)*8 +: 8];
        if (!ty[2] && v[n*8-1]) begin
            for (int b = n * 8; b < 64; b++) v[b] = 1'b1;
        end
        return v[31:0];
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [31:0] a, input logic [2:0] ty);
        logic [3:0] s;
        int off;
        s = '0;
        off = int'(a % 4);
        for (int i = 0; i < m_bytes(ty[1:0]); i++) s[off+i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] sd, input logic [31:0] a,
                                            input logic [2:0] ty);
        logic [31:0] w;
        int off;
        w = '0;
        off = int'(a % 4);
        for (int i = 0; i < m_bytes(ty[1:0]); i++) w[(off+i)*8 +: 8] = sd[i*8 +: 8];
        return w;
    endfunction

    // ---------------- stimulus driver ----------------
    // dly = number of REQ cycles before the ack cycle; negative = never ack.
    task automatic run_txn(input logic st, input logic [2:0] ty, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] rd, input int dly);
        int end_c;
        obs_req_cycles = 0; obs_stall_after = 0; obs_done_cyc = -1; obs_mis_cyc = -1;
        obs_err_cyc = -1; obs_done_cnt = 0; obs_pulse_cnt = 0; obs_unstable = 1'b0;
        obs_timeout = 1'b1; obs_we = 1'b0; obs_addr = '0; obs_wdata = '0; obs_wstrb = '0;
        obs_load = o_load_data;
        end_c = -1;
        @(negedge clk);
        i_valid = 1'b1; i_is_store = st; i_ls_type = ty; i_addr = a; i_store_data = sd;
        #1 obs_stall_at_accept = o_stall;
        @(posedge clk);
        #1;
        i_valid = 1'b0; i_is_store = $urandom_range(0, 1); i_ls_type = 3'($urandom);
        i_addr = $urandom; i_store_data = $urandom;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (o_mem_req) begin
                obs_req_cycles++;
                if (obs_req_cycles == 1) begin
                    obs_addr = o_mem_addr; obs_we = o_mem_we;
                    obs_wstrb = o_mem_wstrb; obs_wdata = o_mem_wdata;
                end else if ({obs_addr, obs_we, obs_wstrb, obs_wdata} !==
                             {o_mem_addr, o_mem_we, o_mem_wstrb, o_mem_wdata}) begin
                    obs_unstable = 1'b1;
                end
            end
            if (o_stall) obs_stall_after++;
            if (o_done) begin
                obs_done_cnt++;
                if (obs_done_cyc < 0) begin obs_done_cyc = c; obs_load = o_load_data; end
            end
            if (o_misaligned) begin obs_pulse_cnt++; if (obs_mis_cyc < 0) obs_mis_cyc = c; end
            if (o_bus_error)  begin obs_pulse_cnt++; if (obs_err_cyc < 0) obs_err_cyc = c; end
            if (end_c < 0 && (o_done || o_misaligned || o_bus_error)) end_c = c;
            i_mem_ack   = o_mem_req && (dly >= 0) && (obs_req_cycles == dly + 1);
            i_mem_rdata = i_mem_ack ? rd : $urandom;
            if (end_c >= 0 && c >= end_c + 2) begin
                obs_timeout = 1'b0;
                break;
            end
        end
        i_mem_ack = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        i_valid = 1'b1; i_ls_type = 3'b011; i_addr = 32'h40;
        #1;
        checks++;
        if ({o_stall, o_mem_req, o_mem_we, o_mem_addr, o_mem_wstrb, o_mem_wdata, o_done,
             o_load_data, o_misaligned, o_bus_error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got stall=%b req=%b we=%b addr=%h strb=%h wd=%h done=%b ld=%h mis=%b berr=%b, want all 0",
                     o_stall, o_mem_req, o_mem_we, o_mem_addr, o_mem_wstrb, o_mem_wdata,
                     o_done, o_load_data, o_misaligned, o_bus_error);
        end
        i_valid = 1'b0;
        @(negedge clk);
        i_reset = 1'b0;
        last_load = '0;
    endtask

    task automatic test_load_byte();
        run_txn(1'b0, 3'b000, 32'h101, 32'h0, 32'h0000_8100, 2);
        checks++;
        if (obs_addr !== 32'h100) begin
            errors++; $display("FAIL lb_addr: got %h want %h", obs_addr, 32'h100);
        end
        checks++;
        if (obs_done_cyc !== 4) begin
            errors++; $display("FAIL lb_latency: got %0d want %0d", obs_done_cyc, 4);
        end
        checks++;
        if (obs_load !== 32'hFFFF_FF81) begin
            errors++; $display("FAIL lb_data: got %h want %h", obs_load, 32'hFFFF_FF81);
        end
        checks++;
        if ({obs_we, obs_wstrb, obs_unstable} !== 6'b0) begin
            errors++; $display("FAIL lb_req: got we=%b strb=%b unstable=%b want 0", obs_we, obs_wstrb, obs_unstable);
        end
        last_load = 32'hFFFF_FF81;
    endtask

    task automatic test_load_half_zero_wait();
        run_txn(1'b0, 3'b101, 32'h202, 32'h0, 32'h8001_0000, 0);
        checks++;
        if (obs_load !== 32'h0000_8001) begin
            errors++; $display("FAIL lhu_data: got %h want %h", obs_load, 32'h0000_8001);
        end
        checks++;
        if (obs_done_cyc !== 2) begin
            errors++; $display("FAIL lhu_latency: got %0d want 2", obs_done_cyc);
        end
        checks++;
        if (obs_stall_after !== 1 || obs_stall_at_accept !== 1'b1) begin
            errors++; $display("FAIL lhu_stall: got after=%0d accept=%b want 1 and 1", obs_stall_after, obs_stall_at_accept);
        end
        last_load = 32'h0000_8001;
    endtask

    task automatic test_store_half();
        run_txn(1'b1, 3'b001, 32'h302, 32'h0000_1234, 32'hDEAD_BEEF, 1);
        checks++;
        if ({obs_we, obs_wstrb, obs_wdata, obs_addr} !== {1'b1, 4'b1100, 32'h1234_0000, 32'h300}) begin
            errors++; $display("FAIL sh_req: got we=%b strb=%b wd=%h addr=%h want 1 1100 12340000 300",
                               obs_we, obs_wstrb, obs_wdata, obs_addr);
        end
        checks++;
        if (obs_done_cyc !== 3 || obs_done_cnt !== 1) begin
            errors++; $display("FAIL sh_done: got cyc=%0d cnt=%0d want 3 1", obs_done_cyc, obs_done_cnt);
        end
        checks++;
        if (obs_load !== last_load) begin
            errors++; $display("FAIL sh_load_kept: got %h want %h", obs_load, last_load);
        end
    endtask

    task automatic test_misaligned();
        run_txn(1'b0, 3'b011, 32'h006, 32'h0, 32'h0, 0);
        checks++;
        if (obs_mis_cyc !== 1 || obs_pulse_cnt !== 1) begin
            errors++; $display("FAIL lw_mis_pulse: got cyc=%0d pulses=%0d want 1 1", obs_mis_cyc, obs_pulse_cnt);
        end
        checks++;
        if (obs_req_cycles !== 0 || obs_stall_after !== 0 || obs_stall_at_accept !== 1'b0) begin
            errors++; $display("FAIL lw_mis_noreq: got req=%0d stall=%0d stall_acc=%b want 0 0 0",
                               obs_req_cycles, obs_stall_after, obs_stall_at_accept);
        end
        run_txn(1'b0, 3'b010, 32'h000, 32'h0, 32'h0, 0);
        checks++;
        if (obs_mis_cyc !== 1 || obs_req_cycles !== 0) begin
            errors++; $display("FAIL ld_mis: got cyc=%0d req=%0d want 1 0", obs_mis_cyc, obs_req_cycles);
        end
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 3'b011, 32'h040, 32'h0, 32'h0, -1);
        checks++;
        if (obs_err_cyc !== TO + 1 || obs_req_cycles !== TO || obs_done_cnt !== 0) begin
            errors++; $display("FAIL timeout: got err=%0d req=%0d done=%0d want %0d %0d 0",
                               obs_err_cyc, obs_req_cycles, obs_done_cnt, TO + 1, TO);
        end
        run_txn(1'b0, 3'b011, 32'h044, 32'h0, 32'hCAFE_F00D, 1);
        checks++;
        if (obs_load !== 32'hCAFE_F00D || obs_done_cyc !== 3) begin
            errors++; $display("FAIL after_timeout: got %h cyc=%0d want cafef00d 3", obs_load, obs_done_cyc);
        end
        last_load = 32'hCAFE_F00D;
        // ack on the very cycle the counter expires is a success
        run_txn(1'b0, 3'b000, 32'h047, 32'h0, 32'h7F00_0000, TO - 1);
        checks++;
        if (obs_err_cyc !== -1 || obs_done_cyc !== TO + 1 || obs_load !== 32'h0000_007F) begin
            errors++; $display("FAIL ack_at_expiry: got err=%0d done=%0d ld=%h want -1 %0d 0000007f",
                               obs_err_cyc, obs_done_cyc, obs_load, TO + 1);
        end
        last_load = 32'h0000_007F;
    endtask

    task automatic test_reset_mid();
        int stray;
        stray = 0;
        @(negedge clk);
        i_valid = 1'b1; i_is_store = 1'b0; i_ls_type = 3'b011; i_addr = 32'h80;
        @(posedge clk);
        #1 i_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (o_mem_req !== 1'b1) begin
            errors++; $display("FAIL mid_req_up: got %b want 1", o_mem_req);
        end
        i_reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_stall, o_mem_req, o_mem_we, o_mem_addr, o_mem_wstrb, o_mem_wdata, o_done,
             o_load_data, o_misaligned, o_bus_error} !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: got req=%b addr=%h ld=%h, want all 0",
                               o_mem_req, o_mem_addr, o_load_data);
        end
        i_reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_done || o_bus_error || o_misaligned || o_mem_req) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++; $display("FAIL mid_reset_quiet: got %0d stray cycles want 0", stray);
        end
        run_txn(1'b0, 3'b100, 32'h003, 32'h0, 32'h8100_0000, 0);
        checks++;
        if (obs_load !== 32'h0000_0081) begin
            errors++; $display("FAIL lbu_after_reset: got %h want %h", obs_load, 32'h0000_0081);
        end
        last_load = 32'h0000_0081;
    endtask

    task automatic test_random();
        logic [2:0]  types [8];
        logic [2:0]  ty;
        logic        st;
        logic [31:0] a, sd, rd, exp;
        int          dly;
        types = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b111, 3'b010, 3'b110};
        for (int t = 0; t < 60; t++) begin
            ty  = types[$urandom_range(0, 7)];
            st  = 1'($urandom_range(0, 1));
            a   = $urandom;
            sd  = $urandom;
            rd  = $urandom;
            dly = $urandom_range(0, 4);
            run_txn(st, ty, a, sd, rd, dly);
            checks++;
            if (obs_timeout) begin
                errors++; $display("FAIL rnd_hang[%0d]: no completion want done/misaligned", t);
            end else if (m_mis(ty, a)) begin
                if (obs_mis_cyc !== 1 || obs_req_cycles !== 0 || obs_done_cnt !== 0) begin
                    errors++; $display("FAIL rnd_mis[%0d]: got cyc=%0d req=%0d done=%0d want 1 0 0",
                                       t, obs_mis_cyc, obs_req_cycles, obs_done_cnt);
                end
            end else if (obs_done_cyc !== dly + 2 || obs_done_cnt !== 1 || obs_pulse_cnt !== 0 ||
                         obs_addr !== (a & ~32'h3) || obs_we !== st || obs_unstable) begin
                errors++; $display("FAIL rnd_txn[%0d]: got cyc=%0d addr=%h we=%b unst=%b want %0d %h %b 0",
                                   t, obs_done_cyc, obs_addr, obs_we, obs_unstable, dly + 2, a & ~32'h3, st);
            end else if (st) begin
                if (obs_wstrb !== m_wstrb(a, ty) || obs_wdata !== m_wdata(sd, a, ty) ||
                    obs_load !== last_load) begin
                    errors++; $display("FAIL rnd_store[%0d]: got strb=%b wd=%h ld=%h want %b %h %h",
                                       t, obs_wstrb, obs_wdata, obs_load, m_wstrb(a, ty),
                                       m_wdata(sd, a, ty), last_load);
                end
            end else begin
                exp = m_load(rd, a, ty);
                if (obs_load !== exp || obs_wstrb !== 4'b0) begin
                    errors++; $display("FAIL rnd_load[%0d]: type=%b addr=%h rd=%h got %h strb=%b want %h 0",
                                       t, ty, a, rd, obs_load, obs_wstrb, exp);
                end
                last_load = exp;
            end
        end
    endtask

    initial begin
        i_reset = 1'b1; i_valid = 1'b0; i_is_store = 1'b0; i_ls_type = '0;
        i_addr = '0; i_store_data = '0; i_mem_ack = 1'b0; i_mem_rdata = '0;
        last_load = '0;
        test_reset();
        test_load_byte();
        test_load_half_zero_wait();
        test_store_half();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
